hatch_fetch: RTL and testbench
==============================

Name: hatch_fetch

Overview:
- Instruction prefetch stage between the 48-bit instruction ROM (hatch memory) and the CPU core.
- Keeps a byte-address fetch pointer in 6-byte steps and issues word-indexed reads to a ROM with 1-cycle read latency.
- Buffers returned instructions in a small FIFO and presents them to the CPU over a valid/ready handshake.
- Redirects (branches, jumps) from the core flush the FIFO and discard any read still in flight.

Parameters:
- ROM_AW, 6, ROM word-index width (64 words).
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- RESET_ADDR, 0, byte address fetched first after reset; must be a multiple of 6.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- redirect_valid  in  1  load a new fetch address this cycle
- redirect_addr  in  32  new fetch byte address
- inst_valid  out  1  FIFO head is valid
- inst_ready  in  1  core accepts the FIFO head
- inst_data  out  48  instruction at the FIFO head
- inst_addr  out  32  byte address of inst_data
- rom_en  out  1  ROM read strobe
- rom_index  out  ROM_AW  ROM word index
- rom_data  in  48  ROM read data, valid the cycle after rom_en

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset state:
  - FIFO empty; inst_valid=0, inst_data=0, inst_addr=0.
  - rom_en=0 while rst is high; in-flight flag cleared.
  - fetch_addr=RESET_ADDR; fetch_idx=RESET_ADDR/6.
- Reset mid-operation: aborts everything. A rom_data return in the cycle after rst falls is discarded.
- Read issue:
  - rom_en = !rst && !redirect_valid && (occupancy + inflight < DEPTH).
  - rom_index = fetch_idx.
  - On issue: fetch_idx += 1 and fetch_addr += 6; the in-flight flag is set for the next cycle.
- Wrap-around: when fetch_idx = 2^ROM_AW-1, the next index is 0 and fetch_addr becomes 0. Index and address must never diverge.
- Return path:
  - The cycle after an un-killed issue, {rom_data, issued address} is written to the FIFO tail.
  - The credit rule above guarantees the FIFO is never overrun. An overflow is a design error; flag it with a simulation assertion.
- Output:
  - inst_valid = FIFO not empty; inst_data and inst_addr come from registered FIFO storage (head entry).
  - Pop when inst_valid && inst_ready.
  - Simultaneous push and pop keeps occupancy unchanged; allowed when full (the pop frees a slot) and when empty-with-return (data appears the next cycle; no bypass).
- Redirect:
  - At the redirect_valid edge: FIFO flushed to empty, the in-flight read is killed, fetch_idx = redirect_addr/6 truncated to ROM_AW bits, and fetch_addr = fetch_idx*6.
  - Redirect has priority over a pop in the same cycle; that pop has no effect.
  - Back-to-back redirects: the last one wins.
- Latency:
  - Redirect at cycle t: rom_en=1 with the new index at t+1, rom_data at t+2, inst_valid=1 at t+3.
  - Same 3-cycle latency from the first cycle with rst low.
- Throughput: one instruction per cycle sustained while inst_ready=1.
- Misaligned redirect (redirect_addr%6 != 0): truncating divide; fetch resumes at the containing word.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output port misalign_err (1 bit).
  - Sticky; set at the edge of any redirect whose redirect_addr%6 != 0; cleared only by rst.
  - The redirect still proceeds with the truncated index.
- Undefined: no misalign_err port and no check logic.

Test Plan:
- Reset with RESET_ADDR=0, inst_ready=1, ROM word k = 0x0000_0000_1000+k → inst_valid first at cycle 3 after rst falls; then one instruction per cycle with inst_addr 0,6,12,…; inst_data 0x1000,0x1001,….
- inst_ready=0 for 20 cycles → exactly DEPTH=4 entries buffered, then rom_en stays 0. Raise inst_ready → entries 0..3 drain in order, then fetch resumes with no gap or duplicate.
- redirect_valid with redirect_addr=60 while 3 entries are buffered and a read is in flight → old entries never appear; next accepted instruction is inst_addr=60, inst_data=word 10, valid at t+3.
- Fetch runs past index 63 → inst_addr 378 followed by 0; rom_index 63 followed by 0.
- Redirect and pop in the same cycle, then a redirect on the following cycle (addr 12, then 30) → the popped entry is not re-presented; first instruction out is inst_addr=30.
- With FETCH_MISALIGN_CHECK_EN, redirect_addr=62 → misalign_err=1 from the next cycle until rst; fetch resumes at inst_addr=60.

Source files
------------

// File: rtl/hatch_fetch_if.sv
// Core-side (redirect / instruction handshake) and ROM-side signals of the hatch prefetch stage.
interface hatch_fetch_if #(
    parameter int unsigned ROM_AW = 6
);
    logic              redirect_valid;
    logic [31:0]       redirect_addr;
    logic              inst_valid;
    logic              inst_ready;
    logic [47:0]       inst_data;
    logic [31:0]       inst_addr;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_index;
    logic [47:0]       rom_data;

    // master: the prefetch stage itself
    modport master (
        input  redirect_valid, redirect_addr, inst_ready, rom_data,
        output inst_valid, inst_data, inst_addr, rom_en, rom_index
    );

    // slave: core plus ROM environment
    modport slave (
        output redirect_valid, redirect_addr, inst_ready, rom_data,
        input  inst_valid, inst_data, inst_addr, rom_en, rom_index
    );
endinterface

// File: rtl/hatch_fetch.sv
// Instruction prefetch between the 48-bit hatch ROM and the core: credit-limited reads, small FIFO, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misalign_err output for redirects not on a 6-byte boundary.
module hatch_fetch #(
    parameter int unsigned ROM_AW     = 6,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    hatch_fetch_if.master bus
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic          misalign_err
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ROM_AW-1:0] LAST_IDX  = '1;
    localparam logic [ROM_AW-1:0] RESET_IDX = ROM_AW'(RESET_ADDR / 6);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [47:0] data;
    } entry_t;

    logic [ROM_AW-1:0] fetch_idx;
    logic [31:0]       fetch_addr;
    logic              inflight;
    logic [31:0]       inflight_addr;
    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              issue;
    logic              push;
    logic              pop;
    logic [ROM_AW-1:0] redir_idx;
    logic [31:0]       redir_addr;
    logic [ROM_AW-1:0] next_idx;
    logic [31:0]       next_addr;

    // Credit check counts the in-flight read so the FIFO can never be overrun.
    always_comb begin
        issue      = !rst && !bus.redirect_valid && ((count + CNT_W'(inflight)) < FULL_CNT);
        push       = inflight && !bus.redirect_valid;
        pop        = (count != '0) && bus.inst_ready && !bus.redirect_valid;
        redir_idx  = ROM_AW'(bus.redirect_addr / 32'd6);
        redir_addr = 32'(redir_idx) * 32'd6;
        next_idx   = fetch_idx + ROM_AW'(1);
        next_addr  = fetch_addr + 32'd6;
        if (fetch_idx == LAST_IDX) begin
            next_idx  = '0;
            next_addr = '0;
        end
    end

    assign bus.rom_en     = issue;
    assign bus.rom_index  = fetch_idx;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_data  = mem[rd_ptr].data;
    assign bus.inst_addr  = mem[rd_ptr].addr;

    // Fetch pointer, in-flight tracking and FIFO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_idx     <= RESET_IDX;
            fetch_addr    <= 32'(RESET_ADDR);
            inflight      <= 1'b0;
            inflight_addr <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            mem           <= '{default: '0};
        end else if (bus.redirect_valid) begin
            fetch_idx  <= redir_idx;
            fetch_addr <= redir_addr;
            inflight   <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_addr <= fetch_addr;
                fetch_idx     <= next_idx;
                fetch_addr    <= next_addr;
            end
            if (push) begin
                mem[wr_ptr] <= '{addr: inflight_addr, data: bus.rom_data};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky until reset; the redirect itself still proceeds with the truncated index.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (bus.redirect_valid && ((bus.redirect_addr % 32'd6) != 32'd0)) begin
            misalign_err <= 1'b1;
        end
    end
`endif

    // A push into a full FIFO without a pop means the credit logic is broken.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop) begin
            assert (count < FULL_CNT)
                else $error("hatch_fetch: instruction FIFO overrun");
        end
    end

endmodule

// File: tb/tb_hatch_fetch.sv
// Directed bench for hatch_fetch: reset latency, stall/drain, redirect flush, index wrap, back-to-back redirects.
module tb_hatch_fetch;

    localparam int unsigned ROM_AW = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   nk;

    always #5 clk = ~clk;

    hatch_fetch_if #(.ROM_AW(ROM_AW)) bus ();

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_err;
`endif

    hatch_fetch #(
        .ROM_AW     (ROM_AW),
        .DEPTH      (4),
        .RESET_ADDR (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    // ROM model: word k holds 0x1000 + k, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= 48'h1000 + 48'(bus.rom_index);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input string tag, input int k);
        check({tag, "_valid"}, 64'(bus.inst_valid), 64'd1);
        check({tag, "_addr"},  64'(bus.inst_addr),  64'(6 * (k % 64)));
        check({tag, "_data"},  64'(bus.inst_data),  64'(32'h1000 + (k % 64)));
    endtask

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'd0;
        bus.inst_ready     = 1'b1;
        tick();
        tick();
        #1;
        check("rst_valid",  64'(bus.inst_valid), 64'd0);
        check("rst_data",   64'(bus.inst_data),  64'd0);
        check("rst_addr",   64'(bus.inst_addr),  64'd0);
        check("rst_rom_en", 64'(bus.rom_en),     64'd0);

        // Reset release: rom_en at t+1, data at t+2, inst_valid at t+3.
        tick(); rst = 1'b0; #1;
        check("boot_rom_en", 64'(bus.rom_en),    64'd1);
        check("boot_index",  64'(bus.rom_index), 64'd0);
        check("boot_v1",     64'(bus.inst_valid), 64'd0);
        tick(); #1;
        check("boot_v2",     64'(bus.inst_valid), 64'd0);
        tick(); #1;
        expect_inst("boot_first", 0);
        nk = 1;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            expect_inst("stream", nk);
            nk++;
        end

        // Build up 3 buffered entries with one read in flight, then redirect to 60.
        tick(); bus.inst_ready = 1'b0; #1;
        check("pre_redir_en0", 64'(bus.rom_en), 64'd1);
        tick(); #1;
        check("pre_redir_en1", 64'(bus.rom_en), 64'd1);
        tick(); bus.redirect_valid = 1'b1; bus.redirect_addr = 32'd60; #1;
        check("redir_rom_en", 64'(bus.rom_en), 64'd0);
        expect_inst("redir_old_head", nk);
        tick(); bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1; #1;
        check("redir_t1_en",    64'(bus.rom_en),     64'd1);
        check("redir_t1_index", 64'(bus.rom_index),  64'd10);
        check("redir_t1_valid", 64'(bus.inst_valid), 64'd0);
        tick(); #1;
        check("redir_t2_valid", 64'(bus.inst_valid), 64'd0);
        tick(); #1;
        expect_inst("redir_t3", 10);
        nk = 11;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            expect_inst("post_redir", nk);
            nk++;
        end

        // Long stall: FIFO fills to DEPTH and fetch stops, then drains in order.
        for (int i = 0; i < 20; i++) begin
            tick(); bus.inst_ready = 1'b0; #1;
        end
        check("stall_rom_en", 64'(bus.rom_en), 64'd0);
        expect_inst("stall_head", nk);
        for (int i = 0; i < 8; i++) begin
            tick(); bus.inst_ready = 1'b1; #1;
            expect_inst("drain", nk);
            nk++;
        end

        // Wrap: index 63 is followed by 0, address 378 by 0.
        tick(); bus.redirect_valid = 1'b1; bus.redirect_addr = 32'd360; #1;
        tick(); bus.redirect_valid = 1'b0; #1;
        check("wrap_index0", 64'(bus.rom_index), 64'd60);
        tick(); #1;
        check("wrap_index1", 64'(bus.rom_index), 64'd61);
        check("wrap_v2",     64'(bus.inst_valid), 64'd0);
        nk = 60;
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            expect_inst("wrap", nk);
            check("wrap_index", 64'(bus.rom_index), 64'((nk + 2) % 64));
            nk++;
        end

        // Redirect with a simultaneous pop, then another redirect: last one (30) wins.
        tick(); bus.redirect_valid = 1'b1; bus.redirect_addr = 32'd12; #1;
        check("rr_head_present", 64'(bus.inst_valid), 64'd1);
        tick(); bus.redirect_addr = 32'd30; #1;
        check("rr_flushed", 64'(bus.inst_valid), 64'd0);
        tick(); bus.redirect_valid = 1'b0; #1;
        check("rr_t1_valid", 64'(bus.inst_valid), 64'd0);
        check("rr_t1_index", 64'(bus.rom_index),  64'd5);
        tick(); #1;
        check("rr_t2_valid", 64'(bus.inst_valid), 64'd0);
        tick(); #1;
        expect_inst("rr_first", 5);
        tick(); #1;
        expect_inst("rr_second", 6);

        // Misaligned redirect resumes at the containing word.
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_before", 64'(misalign_err), 64'd0);
`endif
        tick(); bus.redirect_valid = 1'b1; bus.redirect_addr = 32'd62; #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_same_cycle", 64'(misalign_err), 64'd0);
`endif
        tick(); bus.redirect_valid = 1'b0; #1;
        check("mis_index", 64'(bus.rom_index), 64'd10);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_set", 64'(misalign_err), 64'd1);
`endif
        tick(); #1;
        tick(); #1;
        expect_inst("mis_first", 10);
        tick(); #1;
        expect_inst("mis_second", 11);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_sticky", 64'(misalign_err), 64'd1);
`endif

        // Reset mid-stream aborts everything and restarts from RESET_ADDR.
        tick(); rst = 1'b1; #1;
        check("midrst_rom_en", 64'(bus.rom_en), 64'd0);
        tick(); rst = 1'b0; #1;
        check("midrst_valid", 64'(bus.inst_valid), 64'd0);
        check("midrst_index", 64'(bus.rom_index),  64'd0);
        check("midrst_en",    64'(bus.rom_en),     64'd1);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("midrst_mis", 64'(misalign_err), 64'd0);
`endif
        tick(); #1;
        check("midrst_v2", 64'(bus.inst_valid), 64'd0);
        tick(); #1;
        expect_inst("midrst_first", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
